// File: rtl/muntjac_icache_bypass.sv
// Uncached instruction-fetch responder with a one-entry 8-byte line buffer.
// Serves one 32-bit fetch word per request from a 64-bit memory read port;
// the two words of a beat share one memory read via the line buffer.

package muntjac_icache_bypass_pkg;

   typedef enum logic [3:0] {
      IF_PREFETCH     = 4'b0000,
      IF_PREDICT      = 4'b0001,
      IF_MISPREDICT   = 4'b0011,
      IF_PROT_CHANGED = 4'b0101,
      IF_SATP_CHANGED = 4'b0111,
      IF_FENCE_I      = 4'b1001
   } if_reason_e;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_e;

   typedef enum logic [3:0] {
      EXC_CAUSE_INSTR_ADDR_MISALIGN = 4'd0,
      EXC_CAUSE_INSTR_ACCESS_FAULT  = 4'd1,
      EXC_CAUSE_ILLEGAL_INSN        = 4'd2,
      EXC_CAUSE_INSTR_PAGE_FAULT    = 4'd12
   } exc_cause_e;

   typedef struct packed {
      logic        req_valid;
      logic [63:0] req_pc;
      if_reason_e  req_reason;
      priv_lvl_e   req_prv;
      logic        req_sum;
      logic [63:0] req_atp;
   } icache_h2d_t;

   typedef struct packed {
      logic        resp_valid;
      logic [31:0] resp_instr;
      logic        resp_exception;
      exc_cause_e  resp_ex_code;
   } icache_d2h_t;

endpackage

module muntjac_icache_bypass
   import muntjac_icache_bypass_pkg::*;
#(
   parameter int unsigned PhysAddrWidth = 56,
   parameter logic [63:0] ExecBase      = 64'h8000_0000,
   parameter logic [63:0] ExecSize      = 64'h1000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  icache_h2d_t              icache_h2d_i,
   output icache_d2h_t              icache_d2h_o,
   output logic                     mem_req_valid_o,
   input  logic                     mem_req_ready_i,
   output logic [PhysAddrWidth-1:0] mem_req_addr_o,
   input  logic                     mem_resp_valid_i,
   input  logic [63:0]              mem_resp_data_i,
   input  logic                     mem_resp_error_i
);

   localparam int unsigned TagW = PhysAddrWidth - 3;

   typedef enum logic [2:0] {
      IDLE, FAULT, HIT, MREQ, MWAIT, RESP
   } state_e;

   state_e                   r_state;
   logic                     r_mem_req_valid;
   logic [PhysAddrWidth-1:0] r_mem_req_addr;
   logic                     r_pend_sel;     // pc[2] of the outstanding miss
   logic                     r_buf_valid;
   logic [TagW-1:0]          r_buf_tag;
   logic [63:0]              r_buf_data;
   logic                     r_resp_valid;
   logic [31:0]              r_resp_instr;
   logic                     r_resp_exc;
   exc_cause_e               r_resp_code;

   logic [63:0]     w_pc;
   logic [64:0]     w_word;
   logic [64:0]     w_region_end;
   logic            w_fault_atp;
   logic            w_fault_pa;
   logic            w_fault_exec;
   logic            w_fault;
   logic            w_seq;
   logic [TagW-1:0] w_tag;
   logic            w_hit;
   logic [31:0]     w_beat_word;
   logic            w_unused;

   // Request decode: fault checks, buffer lookup and beat word select
   always_comb begin
      w_pc         = icache_h2d_i.req_pc;
      w_word       = {1'b0, w_pc[63:2], 2'b00};
      // 65-bit end so a region reaching the top of the address space cannot wrap
      w_region_end = {1'b0, ExecBase} + {1'b0, ExecSize};
      w_fault_atp  = |icache_h2d_i.req_atp[63:60];
      w_fault_pa   = |w_pc[63:PhysAddrWidth];
      w_fault_exec = (w_word < {1'b0, ExecBase}) || (w_word >= w_region_end);
      w_fault      = w_fault_atp || w_fault_pa || w_fault_exec;
      // Only sequential fetches may reuse the buffer; anything else may follow
      // a code modification or a context change
      w_seq        = (icache_h2d_i.req_reason == IF_PREFETCH) ||
                     (icache_h2d_i.req_reason == IF_PREDICT);
      w_tag        = w_pc[PhysAddrWidth-1:3];
      w_hit        = r_buf_valid && w_seq && (r_buf_tag == w_tag);
      w_beat_word  = r_pend_sel ? mem_resp_data_i[63:32] : mem_resp_data_i[31:0];
   end

   assign w_unused = ^{w_pc[1:0], icache_h2d_i.req_prv, icache_h2d_i.req_sum,
                       icache_h2d_i.req_atp[59:0]};

   // Fetch FSM with registered memory-request and response outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state         <= IDLE;
         r_mem_req_valid <= 1'b0;
         r_mem_req_addr  <= '0;
         r_pend_sel      <= 1'b0;
         r_buf_valid     <= 1'b0;
         r_buf_tag       <= '0;
         r_buf_data      <= '0;
         r_resp_valid    <= 1'b0;
         r_resp_instr    <= '0;
         r_resp_exc      <= 1'b0;
         r_resp_code     <= EXC_CAUSE_INSTR_ADDR_MISALIGN;
      end else begin
         case (r_state)
            IDLE: begin
               if (icache_h2d_i.req_valid) begin
                  if (!w_seq) r_buf_valid <= 1'b0;
                  if (w_fault) begin
                     r_state      <= FAULT;
                     r_resp_valid <= 1'b1;
                     r_resp_exc   <= 1'b1;
                     r_resp_code  <= EXC_CAUSE_INSTR_ACCESS_FAULT;
                  end else if (w_hit) begin
                     r_state      <= HIT;
                     r_resp_valid <= 1'b1;
                     r_resp_exc   <= 1'b0;
                     r_resp_instr <= w_pc[2] ? r_buf_data[63:32] : r_buf_data[31:0];
                  end else begin
                     r_state         <= MREQ;
                     r_mem_req_valid <= 1'b1;
                     r_mem_req_addr  <= {w_tag, 3'b000};
                     r_pend_sel      <= w_pc[2];
                  end
               end
            end
            MREQ: begin
               if (mem_req_ready_i) begin
                  r_state         <= MWAIT;
                  r_mem_req_valid <= 1'b0;
               end
            end
            MWAIT: begin
               if (mem_resp_valid_i) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  if (mem_resp_error_i) begin
                     r_resp_exc  <= 1'b1;
                     r_resp_code <= EXC_CAUSE_INSTR_ACCESS_FAULT;
                     r_buf_valid <= 1'b0;
                  end else begin
                     r_resp_exc   <= 1'b0;
                     r_resp_instr <= w_beat_word;
                     r_buf_valid  <= 1'b1;
                     r_buf_tag    <= r_mem_req_addr[PhysAddrWidth-1:3];
                     r_buf_data   <= mem_resp_data_i;
                  end
               end
            end
            FAULT, HIT, RESP: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
            end
            default: begin
               r_state         <= IDLE;
               r_mem_req_valid <= 1'b0;
               r_resp_valid    <= 1'b0;
            end
         endcase
      end
   end

   // Drive the response struct straight from registers
   always_comb begin
      icache_d2h_o                = '0;
      icache_d2h_o.resp_valid     = r_resp_valid;
      icache_d2h_o.resp_instr     = r_resp_instr;
      icache_d2h_o.resp_exception = r_resp_exc;
      icache_d2h_o.resp_ex_code   = r_resp_code;
   end

   assign mem_req_valid_o = r_mem_req_valid;
   assign mem_req_addr_o  = r_mem_req_addr;

   // The requester must wait for a response before issuing the next fetch
   a_req_only_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      icache_h2d_i.req_valid |-> (r_state == IDLE));

endmodule

// File: tb/tb_muntjac_icache_bypass.sv
// Directed bench for muntjac_icache_bypass: miss/hit/invalidate paths, fault
// checks at the exec-region edges, memory back-pressure, bus error, and reset
// in the middle of a memory read.

module tb_muntjac_icache_bypass;
   import muntjac_icache_bypass_pkg::*;

   logic        clk;
   logic        rst;
   icache_h2d_t h2d;
   icache_d2h_t d2h;
   logic        mreq_valid;
   logic        mreq_ready;
   logic [55:0] mreq_addr;
   logic        mresp_valid;
   logic [63:0] mresp_data;
   logic        mresp_error;

   int n_tot = 0;
   int n_bad = 0;

   muntjac_icache_bypass dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .icache_h2d_i     (h2d),
      .icache_d2h_o     (d2h),
      .mem_req_valid_o  (mreq_valid),
      .mem_req_ready_i  (mreq_ready),
      .mem_req_addr_o   (mreq_addr),
      .mem_resp_valid_i (mresp_valid),
      .mem_resp_data_i  (mresp_data),
      .mem_resp_error_i (mresp_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle request; returns in cycle N+1
   task automatic req(input logic [63:0] pc, input if_reason_e rsn, input logic [63:0] atp);
      h2d.req_valid  = 1'b1;
      h2d.req_pc     = pc;
      h2d.req_reason = rsn;
      h2d.req_atp    = atp;
      tick();
      h2d.req_valid  = 1'b0;
   endtask

   // Accept the pending read, return one beat; returns in the response cycle
   task automatic mem_beat(input logic [63:0] data, input logic err);
      mreq_ready = 1'b1;
      tick();
      mreq_ready = 1'b0;
      chk("mreq_drop", mreq_valid, 0);
      mresp_valid = 1'b1;
      mresp_data  = data;
      mresp_error = err;
      chk("no_early_resp", d2h.resp_valid, 0);
      tick();
      mresp_valid = 1'b0;
      mresp_error = 1'b0;
   endtask

   typedef struct {
      logic [63:0] pc;
      logic [63:0] atp;
   } fvec_t;

   initial begin
      fvec_t fv [4];
      fv[0] = '{64'h0000_0000_7FFF_FFFC, 64'h0};
      fv[1] = '{64'h0000_0000_9000_0000, 64'h0};
      fv[2] = '{64'h0100_0000_0000_0000, 64'h0};
      fv[3] = '{64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000};

      h2d         = '0;
      mreq_ready  = 1'b0;
      mresp_valid = 1'b0;
      mresp_data  = '0;
      mresp_error = 1'b0;
      rst         = 1'b1;
      tick();
      tick();
      chk("rst_resp_valid", d2h.resp_valid, 0);
      chk("rst_resp_exc", d2h.resp_exception, 0);
      chk("rst_mreq_valid", mreq_valid, 0);
      rst = 1'b0;
      tick();

      // Cold miss through memory, low word
      req(64'h8000_0000, IF_FENCE_I, 64'h0);
      chk("t1_mreq_valid", mreq_valid, 1);
      chk("t1_mreq_addr", mreq_addr, 64'h8000_0000);
      chk("t1_resp_early", d2h.resp_valid, 0);
      mem_beat(64'h1111_2222_3333_4444, 1'b0);
      chk("t1_resp_valid", d2h.resp_valid, 1);
      chk("t1_resp_exc", d2h.resp_exception, 0);
      chk("t1_resp_instr", d2h.resp_instr, 64'h3333_4444);
      tick();
      chk("t1_pulse", d2h.resp_valid, 0);

      // Sequential hit on the upper word
      req(64'h8000_0004, IF_PREFETCH, 64'h0);
      chk("t2_resp_valid", d2h.resp_valid, 1);
      chk("t2_resp_instr", d2h.resp_instr, 64'h1111_2222);
      chk("t2_no_mreq", mreq_valid, 0);
      tick();

      // Same beat with FENCE_I must re-read memory
      req(64'h8000_0004, IF_FENCE_I, 64'h0);
      chk("t3_mreq_valid", mreq_valid, 1);
      chk("t3_mreq_addr", mreq_addr, 64'h8000_0000);
      chk("t3_resp_early", d2h.resp_valid, 0);
      mem_beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      chk("t3_resp_instr", d2h.resp_instr, 64'hAAAA_BBBB);
      tick();

      // Access faults: below base, at end, PA overflow, translation enabled
      for (int i = 0; i < 4; i++) begin
         req(fv[i].pc, IF_PREFETCH, fv[i].atp);
         chk($sformatf("flt%0d_valid", i), d2h.resp_valid, 1);
         chk($sformatf("flt%0d_exc", i), d2h.resp_exception, 1);
         chk($sformatf("flt%0d_code", i), d2h.resp_ex_code, EXC_CAUSE_INSTR_ACCESS_FAULT);
         chk($sformatf("flt%0d_no_mreq", i), mreq_valid, 0);
         tick();
         chk($sformatf("flt%0d_no_mreq2", i), mreq_valid, 0);
      end

      // Last word of the exec region is legal
      req(64'h8FFF_FFFC, IF_PREDICT, 64'h0);
      chk("top_mreq_valid", mreq_valid, 1);
      chk("top_mreq_addr", mreq_addr, 64'h8FFF_FFF8);
      mem_beat(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
      chk("top_resp_exc", d2h.resp_exception, 0);
      chk("top_resp_instr", d2h.resp_instr, 64'hDEAD_BEEF);
      tick();

      // Back-pressure then bus error
      req(64'h8000_0100, IF_FENCE_I, 64'h0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_valid", i), mreq_valid, 1);
         chk($sformatf("bp%0d_addr", i), mreq_addr, 64'h8000_0100);
         tick();
      end
      mem_beat(64'h0123_4567_89AB_CDEF, 1'b1);
      chk("err_resp_valid", d2h.resp_valid, 1);
      chk("err_resp_exc", d2h.resp_exception, 1);
      chk("err_resp_code", d2h.resp_ex_code, EXC_CAUSE_INSTR_ACCESS_FAULT);
      tick();
      req(64'h8000_0104, IF_PREFETCH, 64'h0);
      chk("err_refetch_mreq", mreq_valid, 1);
      chk("err_refetch_noresp", d2h.resp_valid, 0);
      mem_beat(64'h0123_4567_89AB_CDEF, 1'b0);
      chk("err_refetch_instr", d2h.resp_instr, 64'h0123_4567);
      tick();

      // Reset while waiting for data; stray beat afterwards is ignored
      req(64'h8000_0200, IF_FENCE_I, 64'h0);
      mreq_ready = 1'b1;
      tick();
      mreq_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_mreq", mreq_valid, 0);
      mresp_valid = 1'b1;
      mresp_data  = 64'hFFFF_EEEE_DDDD_CCCC;
      tick();
      mresp_valid = 1'b0;
      chk("mrst_stray0", d2h.resp_valid, 0);
      tick();
      chk("mrst_stray1", d2h.resp_valid, 0);
      req(64'h8000_0204, IF_PREFETCH, 64'h0);
      chk("mrst_next_mreq", mreq_valid, 1);
      chk("mrst_next_addr", mreq_addr, 64'h8000_0200);
      mem_beat(64'h5555_6666_7777_8888, 1'b0);
      chk("mrst_next_valid", d2h.resp_valid, 1);
      chk("mrst_next_instr", d2h.resp_instr, 64'h5555_6666);
      tick();

      // pc[1] is ignored on a hit
      req(64'h8000_0206, IF_PREDICT, 64'h0);
      chk("pc1_hit_valid", d2h.resp_valid, 1);
      chk("pc1_hit_instr", d2h.resp_instr, 64'h5555_6666);
      chk("pc1_no_mreq", mreq_valid, 0);
      tick();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
